// File: rtl/fb_pixel_writer.sv
// Framebuffer write port: packs raster pixels into 8-pixel DDR3 bursts
// and issues MIG write commands, pulsing render_complete per frame.
`ifndef FB_ADDR_WIDTH
`define FB_ADDR_WIDTH 19
`endif
`ifndef FB_MAX_ADDR
`define FB_MAX_ADDR 307200
`endif

module fb_pixel_writer #(
    parameter int FB_ADDR_WIDTH      = `FB_ADDR_WIDTH,
    parameter int FB_MAX_ADDR        = `FB_MAX_ADDR,
    parameter int PIXEL_BURST_LENGTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_start,
    input  logic                     pix_valid,
    input  logic [15:0]              pix_data,
    output logic                     pix_ready,
    input  logic                     ddr3_app_rdy,
    input  logic                     ddr3_app_wdf_rdy,
    output logic                     ddr3_app_en,
    output logic [2:0]               ddr3_app_cmd,
    output logic [FB_ADDR_WIDTH-1:0] ddr3_app_addr,
    output logic [63:0]              ddr3_app_wdf_data,
    output logic                     ddr3_app_wdf_wren,
    output logic                     ddr3_app_wdf_end,
    output logic                     render_complete,
    output logic                     busy
);

    localparam logic [FB_ADDR_WIDTH-1:0] STEP =
        FB_ADDR_WIDTH'(PIXEL_BURST_LENGTH);
    localparam logic [FB_ADDR_WIDTH-1:0] LAST_ADDR =
        FB_ADDR_WIDTH'(FB_MAX_ADDR - PIXEL_BURST_LENGTH);

    typedef enum logic [2:0] {
        IDLE, FILL, WRITE_DATA, WRITE_CMD, DONE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [2:0]  cnt;
    logic        beat;
    logic        pending;
    logic [15:0] pix_buf [8];

    logic pix_fire;
    logic beat_fire;
    logic cmd_fire;
    logic restart;

    logic en_d;
    logic wren_d;
    logic beat_d;
    logic end_d;
    logic rc_d;
    logic busy_d;

    assign pix_ready    = (state == FILL);
    assign pix_fire     = pix_ready & pix_valid;
    assign beat_fire    = (state == WRITE_DATA) & ddr3_app_wdf_wren
                        & ddr3_app_wdf_rdy;
    assign cmd_fire     = (state == WRITE_CMD) & ddr3_app_en & ddr3_app_rdy;
    assign restart      = pending | frame_start;
    assign ddr3_app_cmd = 3'b000;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (frame_start) next_state = FILL;
            FILL: begin
                if (frame_start)
                    next_state = FILL;
                else if (pix_fire && cnt == 3'd7)
                    next_state = WRITE_DATA;
            end
            WRITE_DATA: if (beat_fire && beat) next_state = WRITE_CMD;
            WRITE_CMD: begin
                if (cmd_fire) begin
                    if (restart)
                        next_state = FILL;
                    else if (ddr3_app_addr == LAST_ADDR)
                        next_state = DONE;
                    else
                        next_state = FILL;
                end
            end
            DONE:    next_state = frame_start ? FILL : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs are decoded from the state being entered.
    always_comb begin
        en_d   = (next_state == WRITE_CMD);
        wren_d = (next_state == WRITE_DATA);
        beat_d = wren_d & (beat | beat_fire);
        end_d  = wren_d & beat_d;
        rc_d   = (next_state == DONE);
        busy_d = (next_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ddr3_app_en       <= 1'b0;
            ddr3_app_wdf_wren <= 1'b0;
            ddr3_app_wdf_end  <= 1'b0;
            render_complete   <= 1'b0;
            busy              <= 1'b0;
            beat              <= 1'b0;
        end else begin
            ddr3_app_en       <= en_d;
            ddr3_app_wdf_wren <= wren_d;
            ddr3_app_wdf_end  <= end_d;
            render_complete   <= rc_d;
            busy              <= busy_d;
            beat              <= beat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pix_fire) pix_buf[cnt] <= pix_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ddr3_app_addr     <= '0;
            ddr3_app_wdf_data <= '0;
            cnt               <= '0;
            pending           <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (frame_start) begin
                        ddr3_app_addr <= '0;
                        cnt           <= '0;
                    end
                end
                FILL: begin
                    if (frame_start) begin
                        ddr3_app_addr <= '0;
                        cnt           <= '0;
                    end else if (pix_fire) begin
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7)
                            ddr3_app_wdf_data <= {pix_buf[0], pix_buf[1],
                                                  pix_buf[2], pix_buf[3]};
                    end
                end
                WRITE_DATA: begin
                    if (frame_start) pending <= 1'b1;
                    if (beat_fire && !beat)
                        ddr3_app_wdf_data <= {pix_buf[4], pix_buf[5],
                                              pix_buf[6], pix_buf[7]};
                end
                WRITE_CMD: begin
                    // A restart seen during the burst takes effect here.
                    if (cmd_fire) begin
                        pending       <= 1'b0;
                        cnt           <= '0;
                        ddr3_app_addr <= restart ? '0 : ddr3_app_addr + STEP;
                    end else if (frame_start) begin
                        pending <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
